eth_tx_frame_arbiter: RTL and testbench
=======================================

Name: eth_tx_frame_arbiter

Overview:
- Shares the single 64-bit Ethernet MAC TX AXI-Stream input (MAC TX FIFO, clocked by the GT user clock) between PORTS independent frame sources.
- Arbitrates round-robin at frame granularity and never interleaves beats of two frames.
- Enforces a maximum frame length: over-long frames are truncated and marked bad via tuser, so the MAC FIFO discards them.
- Exposes grant and frame/truncation counters for the status register block.

Parameters:
- PORTS, 4, number of requesting streams (2..16).
- DATA_WIDTH, 64, AXIS data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, AXIS tkeep width.
- MAX_BEATS, 1024, maximum beats per frame; 0 disables truncation.

Ports:
- clk  in  1  stream clock (MAC logic/tx clock).
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  PORTS*DATA_WIDTH  input data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  PORTS*KEEP_WIDTH  input byte enables, packed the same way.
- s_axis_tvalid  in  PORTS  per-port valid.
- s_axis_tready  out  PORTS  per-port ready.
- s_axis_tlast  in  PORTS  per-port end of frame.
- s_axis_tuser  in  PORTS  per-port bad-frame flag.
- m_axis_tdata  out  DATA_WIDTH  data to MAC.
- m_axis_tkeep  out  KEEP_WIDTH  byte enables to MAC.
- m_axis_tvalid  out  1  valid to MAC.
- m_axis_tready  in  1  ready from MAC.
- m_axis_tlast  out  1  end of frame to MAC.
- m_axis_tuser  out  1  bad-frame flag to MAC.
- grant_port  out  $clog2(PORTS)  index of the currently or last granted port.
- busy  out  1  1 while in PASS or DROP.
- frame_count  out  32  frames completed on the output, including truncated frames; wraps.
- trunc_count  out  16  frames truncated; saturates at 0xFFFF.

Behaviour:
- One clock domain. rst is synchronous, active-high, and takes priority over all other logic.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_port=0.
  - beat_cnt=0, frame_count=0, trunc_count=0.
  - s_axis_tready=0, m_axis_tvalid=0, busy=0.
- States: IDLE, PASS, DROP.
- IDLE:
  - m_axis_tvalid=0 and all s_axis_tready=0.
  - If any s_axis_tvalid is set, register grant_port = first port with tvalid set, searching from rr_ptr upward and wrapping modulo PORTS.
  - Clear beat_cnt and go to PASS on the next cycle.
  - Arbitration costs exactly one idle cycle per frame.
- PASS (combinational through-path, zero latency):
  - m_axis_{tdata,tkeep,tvalid,tlast,tuser} = granted port's signals.
  - s_axis_tready[grant_port] = m_axis_tready; all other ready bits are 0.
  - An accepted beat is m_axis_tvalid & m_axis_tready; each one increments beat_cnt.
  - Accepted beat with tlast=1: frame_count++, rr_ptr = (grant_port+1) mod PORTS, go to IDLE.
  - MAX_BEATS>0 and an accepted beat with beat_cnt==MAX_BEATS-1 and input tlast=0:
    - this beat is driven with m_axis_tlast=1 and m_axis_tuser=1;
    - frame_count++, trunc_count++ (saturating), go to DROP.
  - A truncation beat whose input tlast=1 is a normal end of frame: no truncation, no DROP.
  - Input tvalid deasserting mid-frame: stay in PASS, hold the grant, m_axis_tvalid follows the input; no timeout.
- DROP:
  - m_axis_tvalid=0; s_axis_tready[grant_port]=1.
  - Consume beats until an input beat with tlast=1 is accepted.
  - Then rr_ptr = (grant_port+1) mod PORTS, go to IDLE.
- Single-beat frames (tlast on the first beat) are legal: 2 cycles per frame when m_axis_tready is high.
- A port holding tvalid continuously is served at most once per rotation when other ports are requesting.
- rst mid-frame returns to IDLE on the next edge. The partial frame is not completed; the downstream FIFO is reset by the same system reset.
- Unused upper grant_port codes never occur.

Test Plan:
- Port 2 sends a 3-beat frame (tdata 0x11,0x22,0x33; tkeep 0xFF,0xFF,0x0F), m_axis_tready=1 → output is the identical 3 beats, tlast on beat 3, grant_port=2, frame_count=1, one idle cycle before the first beat.
- Ports 0,1,3 hold tvalid continuously with 2-beat frames → grant sequence 0,1,3,0,1,3; no beat interleaving; frame_count=6 after six frames.
- MAX_BEATS=4, port 1 sends 6 beats → output is beats 1-4 with beat 4 tlast=1,tuser=1; beats 5-6 accepted with m_axis_tvalid=0; trunc_count=1, frame_count=1; next grant goes to port 2 if requesting.
- Frame of exactly MAX_BEATS=4 beats with tlast on beat 4 → passed intact, tuser=0, trunc_count=0.
- m_axis_tready toggled 1,0,0,1 during a port-0 frame → output data is held stable while stalled; s_axis_tready[0] mirrors m_axis_tready; no beats lost or duplicated.
- rst asserted for one cycle mid-frame on port 3 → next cycle all ready bits=0, m_axis_tvalid=0, counters=0; a new port-0 request is granted first.

Source files
------------

// File: rtl/eth_tx_frame_arbiter.sv
// rtl/eth_tx_frame_arbiter.sv - frame-granular round-robin arbiter feeding one MAC TX AXI-Stream
// Over-long frames are cut at MAX_BEATS, flagged bad via tuser, and the remainder is drained.
module eth_tx_frame_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_BEATS  = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS-1:0]              s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [$clog2(PORTS)-1:0]      grant_port,
  output logic                          busy,
  output logic [31:0]                   frame_count,
  output logic [15:0]                   trunc_count
);

  localparam int PW = $clog2(PORTS);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t                state, state_next;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         rr_after;
  logic [31:0]           beat_cnt;
  logic [PW-1:0]         pick;
  logic                  pick_valid;
  int                    idx;

  logic [DATA_WIDTH-1:0] in_data;
  logic [KEEP_WIDTH-1:0] in_keep;
  logic                  in_valid, in_last, in_user;
  logic                  trunc_hit, accept;

  assign in_data  = s_axis_tdata[int'(grant_port)*DATA_WIDTH +: DATA_WIDTH];
  assign in_keep  = s_axis_tkeep[int'(grant_port)*KEEP_WIDTH +: KEEP_WIDTH];
  assign in_valid = s_axis_tvalid[grant_port];
  assign in_last  = s_axis_tlast[grant_port];
  assign in_user  = s_axis_tuser[grant_port];
  assign rr_after = (grant_port == PW'(PORTS - 1)) ? '0 : grant_port + 1'b1;
  assign busy     = (state != IDLE);

  // A beat that already carries tlast at the limit is a normal end of frame.
  assign trunc_hit = (MAX_BEATS > 0) && (beat_cnt == 32'(MAX_BEATS - 1)) && !in_last;

  // Reverse scan so the port closest to rr_ptr is the last, winning, assignment.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % PORTS;
      if (s_axis_tvalid[idx]) begin
        pick       = PW'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_next = PASS;
      end
      PASS: begin
        m_axis_tdata              = in_data;
        m_axis_tkeep              = in_keep;
        m_axis_tvalid             = in_valid;
        m_axis_tlast              = in_last | trunc_hit;
        m_axis_tuser              = in_user | trunc_hit;
        s_axis_tready[grant_port] = m_axis_tready;
        accept                    = in_valid & m_axis_tready;
        if (accept && in_last)        state_next = IDLE;
        else if (accept && trunc_hit) state_next = DROP;
      end
      DROP: begin
        s_axis_tready[grant_port] = 1'b1;
        if (in_valid && in_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_port  <= '0;
      beat_cnt    <= '0;
      frame_count <= '0;
      trunc_count <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (pick_valid) grant_port <= pick;
        end
        PASS: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (in_last || trunc_hit) frame_count <= frame_count + 1'b1;
            if (in_last) rr_ptr <= rr_after;
            else if (trunc_hit && trunc_count != 16'hFFFF) trunc_count <= trunc_count + 1'b1;
          end
        end
        DROP: begin
          if (in_valid && in_last) rr_ptr <= rr_after;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb/tb_eth_tx_frame_arbiter.sv - directed bench for eth_tx_frame_arbiter
// Arbiter built with PORTS=4, MAX_BEATS=4 so truncation is reachable with short frames.
module tb_eth_tx_frame_arbiter;
  localparam int P  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [P*DW-1:0] s_tdata;
  logic [P*KW-1:0] s_tkeep;
  logic [P-1:0]  s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic [1:0]    grant;
  logic          busy;
  logic [31:0]   frame_cnt;
  logic [15:0]   trunc_cnt;

  int compared   = 0;
  int mismatched = 0;
  int b[P];
  int exp_seq[6] = '{0, 1, 3, 0, 1, 3};
  int e;

  always #5 clk = ~clk;

  eth_tx_frame_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .grant_port(grant), .busy(busy), .frame_count(frame_cnt), .trunc_count(trunc_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l);
    s_tvalid[p]          = v;
    s_tdata[p*DW +: DW]  = d;
    s_tkeep[p*KW +: KW]  = k;
    s_tlast[p]           = l;
    s_tuser[p]           = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < P; p++) drive(p, 1'b0, 64'h0, 8'h0, 1'b0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    m_tready = 1'b1;
    do_reset();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_sready", s_tready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_frames", frame_cnt, 0);
    chk("rst_truncs", trunc_cnt, 0);

    // port 2, three beats, one idle arbitration cycle
    drive(2, 1'b1, 64'h11, 8'hFF, 1'b0); #1;
    chk("t1_idle_mvalid", m_tvalid, 0);
    chk("t1_idle_sready", s_tready, 0);
    step();
    chk("t1_grant", grant, 2);
    chk("t1_b1_valid", m_tvalid, 1);
    chk("t1_b1_data", m_tdata, 64'h11);
    chk("t1_b1_keep", m_tkeep, 8'hFF);
    chk("t1_b1_last", m_tlast, 0);
    chk("t1_sready", s_tready, 4'b0100);
    chk("t1_busy", busy, 1);
    step(); drive(2, 1'b1, 64'h22, 8'hFF, 1'b0); #1;
    chk("t1_b2_data", m_tdata, 64'h22);
    step(); drive(2, 1'b1, 64'h33, 8'h0F, 1'b1); #1;
    chk("t1_b3_data", m_tdata, 64'h33);
    chk("t1_b3_keep", m_tkeep, 8'h0F);
    chk("t1_b3_last", m_tlast, 1);
    chk("t1_b3_user", m_tuser, 0);
    step(); drive(2, 1'b0, 64'h0, 8'h0, 1'b0); #1;
    chk("t1_frames", frame_cnt, 1);
    chk("t1_end_mvalid", m_tvalid, 0);
    chk("t1_end_busy", busy, 0);

    // ports 0,1,3 continuously requesting two-beat frames
    do_reset();
    for (int p = 0; p < P; p++) b[p] = 0;
    for (int p = 0; p < P; p++) if (p != 2) drive(p, 1'b1, 64'(p*16 + b[p]), 8'hFF, b[p] == 1);
    #1;
    chk("t2_idle_mvalid", m_tvalid, 0);
    for (int f = 0; f < 6; f++) begin
      e = exp_seq[f];
      step();
      chk($sformatf("t2_f%0d_grant", f), grant, 64'(e));
      chk($sformatf("t2_f%0d_b0", f), m_tdata, 64'(e*16));
      chk($sformatf("t2_f%0d_b0_last", f), m_tlast, 0);
      chk($sformatf("t2_f%0d_sready", f), s_tready, 64'(1 << e));
      step();
      b[e] = 1;
      for (int p = 0; p < P; p++) if (p != 2) drive(p, 1'b1, 64'(p*16 + b[p]), 8'hFF, b[p] == 1);
      #1;
      chk($sformatf("t2_f%0d_b1", f), m_tdata, 64'(e*16 + 1));
      chk($sformatf("t2_f%0d_b1_last", f), m_tlast, 1);
      step();
      b[e] = 0;
      for (int p = 0; p < P; p++) if (p != 2) drive(p, 1'b1, 64'(p*16 + b[p]), 8'hFF, b[p] == 1);
      #1;
      chk($sformatf("t2_f%0d_gap", f), m_tvalid, 0);
    end
    for (int p = 0; p < P; p++) drive(p, 1'b0, 64'h0, 8'h0, 1'b0);
    step();
    chk("t2_frames", frame_cnt, 6);

    // port 1 sends 6 beats with MAX_BEATS=4, port 2 waiting
    do_reset();
    drive(1, 1'b1, 64'h101, 8'hFF, 1'b0);
    drive(2, 1'b1, 64'h201, 8'hFF, 1'b1);
    #1;
    step();
    chk("t3_grant", grant, 1);
    chk("t3_b1", m_tdata, 64'h101);
    chk("t3_sready", s_tready, 4'b0010);
    chk("t3_b1_last", m_tlast, 0);
    for (int k = 2; k <= 4; k++) begin
      step(); drive(1, 1'b1, 64'(256 + k), 8'hFF, 1'b0); #1;
      chk($sformatf("t3_b%0d", k), m_tdata, 64'(256 + k));
      chk($sformatf("t3_b%0d_last", k), m_tlast, 64'(k == 4));
      chk($sformatf("t3_b%0d_user", k), m_tuser, 64'(k == 4));
    end
    step(); drive(1, 1'b1, 64'h105, 8'hFF, 1'b0); #1;
    chk("t3_drop5_mvalid", m_tvalid, 0);
    chk("t3_drop5_sready", s_tready, 4'b0010);
    chk("t3_drop_busy", busy, 1);
    chk("t3_drop_truncs", trunc_cnt, 1);
    chk("t3_drop_frames", frame_cnt, 1);
    step(); drive(1, 1'b1, 64'h106, 8'hFF, 1'b1); #1;
    chk("t3_drop6_mvalid", m_tvalid, 0);
    step(); drive(1, 1'b0, 64'h0, 8'h0, 1'b0); #1;
    chk("t3_idle_busy", busy, 0);
    chk("t3_truncs", trunc_cnt, 1);
    chk("t3_frames", frame_cnt, 1);
    step();
    chk("t3_next_grant", grant, 2);
    chk("t3_p2_data", m_tdata, 64'h201);
    chk("t3_p2_last", m_tlast, 1);
    chk("t3_p2_user", m_tuser, 0);
    step(); drive(2, 1'b0, 64'h0, 8'h0, 1'b0); #1;
    chk("t3_frames2", frame_cnt, 2);

    // exactly MAX_BEATS beats with tlast on the last one
    do_reset();
    drive(0, 1'b1, 64'hA1, 8'hFF, 1'b0); #1;
    step();
    chk("t4_grant", grant, 0);
    chk("t4_b1", m_tdata, 64'hA1);
    for (int k = 2; k <= 4; k++) begin
      step(); drive(0, 1'b1, 64'(160 + k), 8'hFF, k == 4); #1;
      chk($sformatf("t4_b%0d", k), m_tdata, 64'(160 + k));
    end
    chk("t4_last", m_tlast, 1);
    chk("t4_user", m_tuser, 0);
    step(); drive(0, 1'b0, 64'h0, 8'h0, 1'b0); #1;
    chk("t4_truncs", trunc_cnt, 0);
    chk("t4_frames", frame_cnt, 1);
    chk("t4_busy", busy, 0);

    // backpressure 1,0,0,1 on a port-0 frame
    drive(0, 1'b1, 64'hB1, 8'hFF, 1'b0); #1;
    step();
    chk("t5_grant", grant, 0);
    chk("t5_b1", m_tdata, 64'hB1);
    chk("t5_sready1", s_tready, 4'b0001);
    step(); drive(0, 1'b1, 64'hB2, 8'hFF, 1'b1); m_tready = 1'b0; #1;
    chk("t5_stall1_data", m_tdata, 64'hB2);
    chk("t5_stall1_sready", s_tready, 4'b0000);
    chk("t5_stall1_valid", m_tvalid, 1);
    step();
    chk("t5_stall2_data", m_tdata, 64'hB2);
    chk("t5_stall2_sready", s_tready, 4'b0000);
    chk("t5_stall2_last", m_tlast, 1);
    step(); m_tready = 1'b1; #1;
    chk("t5_go_data", m_tdata, 64'hB2);
    chk("t5_go_sready", s_tready, 4'b0001);
    step(); drive(0, 1'b0, 64'h0, 8'h0, 1'b0); #1;
    chk("t5_frames", frame_cnt, 2);
    chk("t5_busy", busy, 0);

    // reset in the middle of a port-3 frame
    drive(3, 1'b1, 64'hC1, 8'hFF, 1'b0); #1;
    step();
    chk("t6_grant3", grant, 3);
    step(); drive(3, 1'b1, 64'hC2, 8'hFF, 1'b0);
    drive(0, 1'b1, 64'hD1, 8'hFF, 1'b1);
    rst = 1'b1;
    #1;
    step(); rst = 1'b0; #1;
    chk("t6_sready", s_tready, 0);
    chk("t6_mvalid", m_tvalid, 0);
    chk("t6_frames", frame_cnt, 0);
    chk("t6_truncs", trunc_cnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_grant_rst", grant, 0);
    step();
    chk("t6_grant0", grant, 0);
    chk("t6_data", m_tdata, 64'hD1);
    step(); drive(0, 1'b0, 64'h0, 8'h0, 1'b0); drive(3, 1'b0, 64'h0, 8'h0, 1'b0); #1;
    chk("t6_frames_after", frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
